// File: rtl/nxp_pkg.sv
// Shared definitions for the NAND->XOR pipeline: mode encodings and beat payload layout.
// Payload is {parity, f2, f1}, with f1 in the low WIDTH bits.
package nxp_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_ACCUM  = 1'b1;

   function automatic int payload_w(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/nand_xor_pipe_stage.sv
// One valid/ready register slice: loads when empty or when draining this cycle; 1-cycle latency.
// Holds its payload unchanged while valid and the downstream is not ready.
module nand_xor_pipe_stage #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   input  logic [W-1:0] up_dat,
   input  logic         dn_ready,
   output logic         valid,
   output logic [W-1:0] dat
);

   logic adv;
   logic load;

   assign adv  = valid & dn_ready;
   assign load = up_valid & (~valid | adv);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         dat   <= '0;
      end else if (load) begin
         valid <= 1'b1;
         dat   <= up_dat;
      end else if (adv) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/nand_xor_pipe.sv
// Pipelined NAND->XOR block with accumulator; STAGES cycles latency, 1 beat/cycle.
// Ready is a combinational chain from out_ready; outputs hold while stalled.
module nand_xor_pipe
   import nxp_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             mode,
   input  logic             clr_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] f1,
   output logic [WIDTH-1:0] f2,
   output logic             parity
);

   localparam int PW = payload_w(WIDTH);

   logic [WIDTH-1:0] f1_c;
   logic [WIDTH-1:0] f2_c;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_eff;
   logic [PW-1:0]    pay_c;
   logic             accept;

   logic [STAGES-1:0] vld;
   logic [STAGES:0]   rdy;
   logic [PW-1:0]     dat [STAGES];

   assign acc_eff = clr_acc ? '0 : acc;
   assign f1_c    = ~(a & b);
   assign f2_c    = f1_c ^ ((mode == MODE_ACCUM) ? acc_eff : c);
   assign pay_c   = {^f2_c, f2_c, f1_c};

   // Stage k can take a beat when empty or when everything below it can move.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = ~vld[k] | rdy[k+1];
      end
   end

   assign in_ready = rdy[0];
   assign accept   = in_valid & rdy[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (accept) begin
         if (mode == MODE_ACCUM) begin
            acc <= f2_c;
         end else if (clr_acc) begin
            acc <= '0;
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         nand_xor_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (in_valid),
            .up_dat   (pay_c),
            .dn_ready (rdy[k+1]),
            .valid    (vld[k]),
            .dat      (dat[k])
         );
      end else begin : g_rest
         nand_xor_pipe_stage #(.W(PW)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .up_valid (vld[k-1]),
            .up_dat   (dat[k-1]),
            .dn_ready (rdy[k+1]),
            .valid    (vld[k]),
            .dat      (dat[k])
         );
      end
   end

   assign out_valid          = vld[STAGES-1];
   assign {parity, f2, f1}   = dat[STAGES-1];

endmodule

// File: tb/tb_nand_xor_pipe.sv
// Scoreboard bench for nand_xor_pipe: driver pushes model results on accept, monitor pops on delivery.
module tb_nand_xor_pipe;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a, b, c;
   logic             mode;
   logic             clr_acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] f1, f2;
   logic             parity;

   always #5 clk = ~clk;

   nand_xor_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c         (c),
      .mode      (mode),
      .clr_acc   (clr_acc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .f1        (f1),
      .f2        (f2),
      .parity    (parity)
   );

   typedef struct {
      logic [WIDTH-1:0] f1;
      logic [WIDTH-1:0] f2;
      logic             par;
      int               t;
   } exp_t;

   exp_t             sb[$];
   logic [WIDTH-1:0] got_f2[$];
   logic [WIDTH-1:0] m_acc;
   logic [WIDTH-1:0] last_f1;
   logic             last_par;
   logic             lat_en;
   logic             rnd_rdy_en;
   logic             hold_vld;
   logic [2*WIDTH:0] hold_val;
   int               n_chk  = 0;
   int               n_fail = 0;
   int               cyc    = 0;
   int               n_out  = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Reference: bitwise NAND then XOR against C or the (optionally cleared) accumulator.
   task automatic push_exp(input logic [WIDTH-1:0] ai, bi, ci, input logic m, input logic clr);
      exp_t e;
      logic [WIDTH-1:0] nand_v;
      nand_v = ~(ai & bi);
      e.f1   = nand_v;
      if (m) begin
         e.f2  = nand_v ^ (clr ? '0 : m_acc);
         m_acc = e.f2;
      end else begin
         e.f2 = nand_v ^ ci;
         if (clr) m_acc = '0;
      end
      e.par = ^e.f2;
      e.t   = cyc;
      sb.push_back(e);
   endtask

   task automatic send(input logic [WIDTH-1:0] ai, bi, ci, input logic m, input logic clr);
      int w;
      w        = 0;
      a        = ai;
      b        = bi;
      c        = ci;
      mode     = m;
      clr_acc  = clr;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         w++;
         if (w > 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
            break;
         end
      end
      if (in_ready) push_exp(ai, bi, ci, m, clr);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      clr_acc  = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 300) begin
         @(posedge clk);
         w++;
      end
      if (sb.size() != 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy_en) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: pops one expected beat per delivery and checks stall stability.
   initial begin
      exp_t e;
      hold_vld = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_vld = 1'b0;
         end else begin
            if (hold_vld && out_valid) chk("hold_stable", 32'({parity, f2, f1}), 32'(hold_val));
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got f2=%0h with empty scoreboard", f2);
               end else begin
                  e = sb.pop_front();
                  chk("f1", 32'(f1), 32'(e.f1));
                  chk("f2", 32'(f2), 32'(e.f2));
                  chk("parity", 32'(parity), 32'(e.par));
                  if (lat_en) chk("latency", 32'(cyc - e.t), 32'(STAGES));
                  got_f2.push_back(f2);
                  last_f1  = f1;
                  last_par = parity;
                  n_out++;
               end
            end
            hold_vld = out_valid && !out_ready;
            hold_val = {parity, f2, f1};
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = '0;
      b          = '0;
      c          = '0;
      mode       = 1'b0;
      clr_acc    = 1'b0;
      out_ready  = 1'b1;
      lat_en     = 1'b0;
      rnd_rdy_en = 1'b0;
      m_acc      = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_f1", 32'(f1), 32'd0);
      chk("rst_f2", 32'(f2), 32'd0);
      chk("rst_parity", 32'(parity), 32'd0);
      @(posedge clk);
      #1;

      // Direct beat
      lat_en = 1'b1;
      got_f2.delete();
      send(8'hFF, 8'h0F, 8'h33, 1'b0, 1'b0);
      drain();
      chk("t1_f1", 32'(last_f1), 32'hF0);
      chk("t1_f2", 32'(got_f2[0]), 32'hC3);
      chk("t1_parity", 32'(last_par), 32'd0);

      // Accumulate from a cleared accumulator, then expose acc through f1=00
      got_f2.delete();
      send(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      send(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      send(8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      send(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
      drain();
      chk("t2_count", 32'(got_f2.size()), 32'd4);
      chk("t2_f2_0", 32'(got_f2[0]), 32'hFF);
      chk("t2_f2_1", 32'(got_f2[1]), 32'h00);
      chk("t2_f2_2", 32'(got_f2[2]), 32'hFF);
      chk("t2_acc_end", 32'(got_f2[3]), 32'hFF);

      // Back-pressure: two beats fill the pipe, the third must wait
      lat_en    = 1'b0;
      out_ready = 1'b0;
      got_f2.delete();
      send(8'h11, 8'h22, 8'h01, 1'b0, 1'b0);
      send(8'h33, 8'h44, 8'h02, 1'b0, 1'b0);
      a        = 8'h55;
      b        = 8'h66;
      c        = 8'h03;
      mode     = 1'b0;
      in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_in_ready_full", 32'(in_ready), 32'd0);
         chk("t3_out_valid_full", 32'(out_valid), 32'd1);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(8'h55, 8'h66, 8'h03, 1'b0, 1'b0);
      send(8'h77, 8'h88, 8'h04, 1'b0, 1'b0);
      drain();
      chk("t3_count", 32'(got_f2.size()), 32'd4);

      // Streaming: latency check per beat proves no bubbles
      lat_en = 1'b1;
      n0     = n_out;
      for (int i = 0; i < 16; i++) begin
         send(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
      end
      drain();
      chk("t4_count", 32'(n_out - n0), 32'd16);

      // Random back-pressure and idle gaps
      lat_en     = 1'b0;
      rnd_rdy_en = 1'b1;
      n0         = n_out;
      for (int i = 0; i < 30; i++) begin
         send(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      drain();
      rnd_rdy_en = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      chk("rnd_count", 32'(n_out - n0), 32'd30);

      // Reset mid-stream with two beats in flight
      out_ready = 1'b0;
      send(8'h12, 8'h34, 8'h00, 1'b1, 1'b0);
      send(8'h56, 8'h78, 8'h00, 1'b1, 1'b0);
      rst = 1'b1;
      sb.delete();
      m_acc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_out_valid", 32'(out_valid), 32'd0);
      chk("t5_f2", 32'(f2), 32'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      lat_en    = 1'b1;
      got_f2.delete();
      send(8'h5A, 8'h3C, 8'h00, 1'b1, 1'b0);
      drain();
      chk("t5_f2_eq_f1", 32'(got_f2[0]), 32'hE7);

      // clr_acc edge cases
      got_f2.delete();
      send(8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
      clr_acc = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clr_acc = 1'b0;
      send(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
      send(8'hF0, 8'h0F, 8'hAA, 1'b0, 1'b1);
      send(8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0);
      drain();
      chk("t6_idle_clr_ignored", 32'(got_f2[1]), 32'hFF);
      chk("t6_direct_clr_f2", 32'(got_f2[2]), 32'h55);
      chk("t6_acc_cleared", 32'(got_f2[3]), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
